// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input synchroniser, oversampled start/data/parity/stop
// recovery, and a valid/ready output register with parity, framing and overrun reporting.
module uart_rx_param #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    input  logic                 data_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rxs_q;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   prev_q, prev_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_out_q, perr_out_d;
    logic                   ferr_out_q, ferr_out_d;
    logic                   overrun_q, overrun_d;
    logic                   deliver_c;

    // State, counters, synchroniser and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            prev_q     <= 1'b1;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            prev_q     <= prev_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            overrun_q  <= overrun_d;
        end
    end

    // Frame recovery FSM, advancing only on tick; delivery handshake runs every cycle
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        prev_d     = prev_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        deliver_c  = 1'b0;
        data_d     = data_q;
        valid_d    = valid_q & ~data_ready;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        overrun_d  = 1'b0;

        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    prev_d = rxs_q;
                    if (prev_q && !rxs_q) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                    end
                end
                S_START: begin
                    if (tick_cnt_q == HALF_LAST) begin
                        if (rxs_q) begin
                            state_d = S_IDLE;
                            prev_d  = 1'b1;
                        end else begin
                            state_d    = S_DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                            perr_d     = 1'b0;
                            ferr_d     = 1'b0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                S_DATA: begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rxs_q, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                S_PARITY: begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        perr_d     = ((^shift_q) ^ rxs_q) != 1'(PARITY_ODD);
                        state_d    = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                S_STOP: begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        ferr_d     = ferr_q | ~rxs_q;
                        if (bit_cnt_q == STOP_LAST) begin
                            // Seeding prev with the stop sample lets an immediate start bit be seen
                            deliver_c = 1'b1;
                            bit_cnt_d = '0;
                            state_d   = S_IDLE;
                            prev_d    = rxs_q;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (deliver_c) begin
            if (!valid_q || data_ready) begin
                data_d     = shift_q;
                perr_out_d = perr_q;
                ferr_out_d = ferr_d;
                valid_d    = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 default instance and a 7-bit even-parity two-stop instance,
// driven bit by bit with expected words queued per instance and compared on acceptance.
module tb_uart_rx_param;

    localparam int BIT = 64;  // 16 ticks per bit, one tick every 4 clk

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] tph = 2'd0;
    int         cyc = 0;
    logic       tick;
    always @(posedge clk) begin
        tph <= tph + 2'd1;
        cyc <= cyc + 1;
    end
    assign tick = (tph == 2'd3);

    logic       reset_a, rx_a, ready_a, valid_a, perr_a, ferr_a, ovr_a;
    logic [7:0] dout_a;
    logic       reset_b, rx_b, ready_b, valid_b, perr_b, ferr_b, ovr_b;
    logic [6:0] dout_b;

    uart_rx_param u_a (
        .clk(clk), .reset(reset_a), .tick(tick), .rx(rx_a), .data_ready(ready_a),
        .data_out(dout_a), .data_valid(valid_a), .parity_err(perr_a),
        .frame_err(ferr_a), .overrun(ovr_a)
    );

    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_b (
        .clk(clk), .reset(reset_b), .tick(tick), .rx(rx_b), .data_ready(ready_b),
        .data_out(dout_b), .data_valid(valid_b), .parity_err(perr_b),
        .frame_err(ferr_b), .overrun(ovr_b)
    );

    typedef struct {
        int         sel;
        logic [8:0] data;
        logic       pbit;
        logic       stop0;
        logic       stop1;
        logic [8:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    vec_t vecs[11];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Per-instance monitors: pop and compare on every accepted word
    logic vprev_a = 1'b0;
    int   rise_a = 0, vcyc_a = 0, ovr_cnt_a = 0;
    always @(negedge clk) begin
        vprev_a <= valid_a;
        if (valid_a && !vprev_a) rise_a <= cyc;
        if (valid_a) vcyc_a <= vcyc_a + 1;
        if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
        if (valid_a && ready_a) begin
            if (q_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word_a actual=%0h required=none", dout_a);
            end else begin
                e_a = q_a.pop_front();
                check("data_a", 32'(dout_a), 32'(e_a.data));
                check("perr_a", 32'(perr_a), 32'(e_a.perr));
                check("ferr_a", 32'(ferr_a), 32'(e_a.ferr));
            end
        end
    end

    int vcyc_b = 0, ovr_cnt_b = 0;
    always @(negedge clk) begin
        if (valid_b) vcyc_b <= vcyc_b + 1;
        if (ovr_b) ovr_cnt_b <= ovr_cnt_b + 1;
        if (valid_b && ready_b) begin
            if (q_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word_b actual=%0h required=none", dout_b);
            end else begin
                e_b = q_b.pop_front();
                check("data_b", 32'(dout_b), 32'(e_b.data));
                check("perr_b", 32'(perr_b), 32'(e_b.perr));
                check("ferr_b", 32'(ferr_b), 32'(e_b.ferr));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else rx_b = v;
    endtask

    task automatic send_frame(input int sel, input logic [8:0] data, input logic pbit,
                              input logic s0, input logic s1);
        int nbits;
        nbits = (sel == 0) ? 8 : 7;
        drive(sel, 1'b0);
        step(BIT);
        for (int i = 0; i < nbits; i++) begin
            drive(sel, data[i]);
            step(BIT);
        end
        if (sel == 1) begin
            drive(sel, pbit);
            step(BIT);
        end
        drive(sel, s0);
        step(BIT);
        if (sel == 1) begin
            drive(sel, s1);
            step(BIT);
        end
    endtask

    task automatic push(input int sel, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        if (sel == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endtask

    task automatic wait_drain(input int sel, input string name);
        int n;
        int sz;
        n  = 0;
        sz = (sel == 0) ? q_a.size() : q_b.size();
        while (sz != 0 && n < 2000) begin
            step(1);
            n++;
            sz = (sel == 0) ? q_a.size() : q_b.size();
        end
        check(name, 32'(sz), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, v0, o0, lat;

        reset_a = 1'b1; reset_b = 1'b1;
        rx_a = 1'b1; rx_b = 1'b1;
        ready_a = 1'b1; ready_b = 1'b1;

        vecs[0]  = '{0, 9'h0A5, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b0, 1'b0};
        vecs[1]  = '{0, 9'h000, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0};
        vecs[2]  = '{0, 9'h0FF, 1'b0, 1'b1, 1'b1, 9'h0FF, 1'b0, 1'b0};
        vecs[3]  = '{0, 9'h03C, 1'b0, 1'b1, 1'b1, 9'h03C, 1'b0, 1'b0};
        vecs[4]  = '{0, 9'h081, 1'b0, 1'b0, 1'b1, 9'h081, 1'b0, 1'b1};
        vecs[5]  = '{1, 9'h007, 1'b1, 1'b1, 1'b1, 9'h007, 1'b0, 1'b0};
        vecs[6]  = '{1, 9'h007, 1'b0, 1'b1, 1'b1, 9'h007, 1'b1, 1'b0};
        vecs[7]  = '{1, 9'h07F, 1'b1, 1'b1, 1'b1, 9'h07F, 1'b0, 1'b0};
        vecs[8]  = '{1, 9'h02A, 1'b0, 1'b1, 1'b1, 9'h02A, 1'b1, 1'b0};
        vecs[9]  = '{1, 9'h055, 1'b0, 1'b1, 1'b0, 9'h055, 1'b0, 1'b1};
        vecs[10] = '{1, 9'h007, 1'b0, 1'b1, 1'b1, 9'h007, 1'b1, 1'b0};

        step(3);
        reset_a = 1'b0; reset_b = 1'b0;
        check("rst_valid_a", 32'(valid_a), 32'd0);
        check("rst_data_a", 32'(dout_a), 32'd0);
        check("rst_flags_a", {29'd0, perr_a, ferr_a, ovr_a}, 32'd0);
        check("rst_valid_b", 32'(valid_b), 32'd0);
        step(BIT);

        for (int i = 0; i < 11; i++) begin
            c0 = cyc;
            v0 = vcyc_a;
            push(vecs[i].sel, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].pbit, vecs[i].stop0, vecs[i].stop1);
            drive(vecs[i].sel, 1'b1);
            step(BIT);
            wait_drain(vecs[i].sel, "vec_drain");
            if (i == 0) begin
                lat = rise_a - c0;
                total++;
                if (lat < 611 || lat > 614) begin
                    bad++;
                    $display("FAIL latency actual=%0d required=611..614", lat);
                end
                check("valid_one_cycle", 32'(vcyc_a - v0), 32'd1);
            end
        end

        // False start: 4 ticks low, then a real frame
        v0 = vcyc_a;
        drive(0, 1'b0);
        step(16);
        drive(0, 1'b1);
        step(2 * BIT);
        check("false_start_no_word", 32'(vcyc_a - v0), 32'd0);
        push(0, 9'h03C, 1'b0, 1'b0);
        send_frame(0, 9'h03C, 1'b0, 1'b1, 1'b1);
        step(BIT);
        wait_drain(0, "after_false_start");

        // Framing error then break: exactly one word until the line recovers
        v0 = vcyc_a;
        push(0, 9'h055, 1'b0, 1'b1);
        send_frame(0, 9'h055, 1'b0, 1'b0, 1'b0);
        step(30 * BIT);
        check("break_one_word", 32'(vcyc_a - v0), 32'd1);
        drive(0, 1'b1);
        step(BIT);
        push(0, 9'h066, 1'b0, 1'b0);
        send_frame(0, 9'h066, 1'b0, 1'b1, 1'b1);
        step(BIT);
        wait_drain(0, "after_break");

        // Back-to-back with a ready consumer
        push(0, 9'h081, 1'b0, 1'b0);
        push(0, 9'h042, 1'b0, 1'b0);
        send_frame(0, 9'h081, 1'b0, 1'b1, 1'b1);
        send_frame(0, 9'h042, 1'b0, 1'b1, 1'b1);
        step(BIT);
        wait_drain(0, "back_to_back");

        // Overrun: stalled consumer, second frame discarded
        ready_a = 1'b0;
        o0 = ovr_cnt_a;
        push(0, 9'h011, 1'b0, 1'b0);
        send_frame(0, 9'h011, 1'b0, 1'b1, 1'b1);
        send_frame(0, 9'h022, 1'b0, 1'b1, 1'b1);
        step(BIT);
        check("ovr_pulses", 32'(ovr_cnt_a - o0), 32'd1);
        check("ovr_valid_held", 32'(valid_a), 32'd1);
        check("ovr_data_held", 32'(dout_a), 32'h11);
        ready_a = 1'b1;
        step(2);
        check("ovr_valid_drop", 32'(valid_a), 32'd0);
        check("ovr_q_empty", 32'(q_a.size()), 32'd0);

        // Reset during data bit 3 of a 7-bit, two-stop frame
        drive(1, 1'b0);
        step(BIT);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1'b0);
            step(BIT);
        end
        drive(1, 1'b0);
        step(20);
        reset_b = 1'b1;
        step(1);
        reset_b = 1'b0;
        drive(1, 1'b1);
        check("rstmid_data", 32'(dout_b), 32'd0);
        check("rstmid_flags", {28'd0, valid_b, perr_b, ferr_b, ovr_b}, 32'd0);
        v0 = vcyc_b;
        step(12 * BIT);
        check("rstmid_no_word", 32'(vcyc_b - v0), 32'd0);
        push(1, 9'h05A, 1'b0, 1'b0);
        send_frame(1, 9'h05A, 1'b0, 1'b1, 1'b1);
        step(BIT);
        wait_drain(1, "after_reset");
        check("ovr_b_none", 32'(ovr_cnt_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
